// File: rtl/regfile_pkg.sv
// Shared defaults, hardwired register indices and the write-legality helper
// for the scoreboarded register file.
package regfile_pkg;

    localparam int unsigned DEF_DATA_W = 16;
    localparam int unsigned DEF_NREGS  = 16;
    localparam int unsigned DEF_NRD    = 2;

    // Hardwired registers: r0 reads as 0, r1 reads as 1.
    localparam int unsigned R0 = 0;
    localparam int unsigned R1 = 1;

    // A register may be written or marked pending only if it is neither
    // hardwired nor beyond the populated range.
    function automatic logic is_writable(input int unsigned addr, input int unsigned nregs);
        return (addr != R0) && (addr != R1) && (addr < nregs);
    endfunction

endpackage

// File: rtl/regfile_scoreboard.sv
// Per-register pending bits with set/clear priority and a registered
// population count of pending registers.
module regfile_scoreboard
    import regfile_pkg::*;
#(
    parameter  int unsigned NREGS = DEF_NREGS,
    localparam int unsigned AW    = $clog2(NREGS),
    localparam int unsigned CW    = $clog2(NREGS + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              set_en_i,
    input  logic [AW-1:0]     set_addr_i,
    input  logic [1:0]        clr_en_i,
    input  logic [2*AW-1:0]   clr_addr_i,
    output logic [NREGS-1:0]  busy_o,
    output logic [CW-1:0]     busy_count_o
);

    logic [NREGS-1:0] busy_d, busy_q;
    logic [CW-1:0]    count_d, count_q;
    logic             set_ok;
    logic [1:0]       clr_ok;
    logic [AW-1:0]    clr_a [2];

    // Decode which set/clear requests target a writable register.
    always_comb begin
        set_ok = set_en_i && is_writable(32'(set_addr_i), NREGS);
        for (int j = 0; j < 2; j++) begin
            clr_a[j]  = clr_addr_i[j*AW +: AW];
            clr_ok[j] = clr_en_i[j] && is_writable(32'(clr_a[j]), NREGS);
        end
    end

    // Next busy bits: writes clear, a same-cycle set overrides the clear.
    always_comb begin
        busy_d = busy_q;
        for (int unsigned i = 0; i < NREGS; i++) begin
            for (int j = 0; j < 2; j++) begin
                if (clr_ok[j] && (32'(clr_a[j]) == i)) begin
                    busy_d[i] = 1'b0;
                end
            end
            if (set_ok && (32'(set_addr_i) == i)) begin
                busy_d[i] = 1'b1;
            end
        end
    end

    // Count of pending registers after the coming edge.
    always_comb begin
        count_d = '0;
        for (int unsigned i = 0; i < NREGS; i++) begin
            count_d = count_d + CW'(busy_d[i]);
        end
    end

    // State update; reset discards any simultaneous set or clear.
    always_ff @(posedge clk) begin
        if (rst) begin
            busy_q  <= '0;
            count_q <= '0;
        end else begin
            busy_q  <= busy_d;
            count_q <= count_d;
        end
    end

    assign busy_o       = busy_q;
    assign busy_count_o = count_q;

endmodule

// File: rtl/regfile_sb.sv
// Multi-read, dual-write register file with hardwired r0/r1, optional
// same-cycle write-to-read forwarding and a per-register pending scoreboard.
module regfile_sb
    import regfile_pkg::*;
#(
    parameter  int unsigned DATA_W = DEF_DATA_W,
    parameter  int unsigned NREGS  = DEF_NREGS,
    parameter  int unsigned NRD    = DEF_NRD,
    parameter  int unsigned BYPASS = 1,
    localparam int unsigned AW     = $clog2(NREGS),
    localparam int unsigned CW     = $clog2(NREGS + 1)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NRD*AW-1:0]     rd_addr,
    output logic [NRD*DATA_W-1:0] rd_data,
    output logic [NRD-1:0]        rd_busy,
    input  logic [1:0]            wr_en,
    input  logic [2*AW-1:0]       wr_addr,
    input  logic [2*DATA_W-1:0]   wr_data,
    input  logic                  sb_set_en,
    input  logic [AW-1:0]         sb_set_addr,
    output logic [CW-1:0]         busy_count
);

    logic [DATA_W-1:0] mem_q [NREGS];
    logic [DATA_W-1:0] mem_d [NREGS];
    logic [AW-1:0]     wa [2];
    logic [DATA_W-1:0] wd [2];
    logic [1:0]        wr_ok;
    logic [AW-1:0]     ra [NRD];
    logic [NREGS-1:0]  busy;

    // Split write ports and qualify each against writable addresses.
    always_comb begin
        for (int j = 0; j < 2; j++) begin
            wa[j]    = wr_addr[j*AW +: AW];
            wd[j]    = wr_data[j*DATA_W +: DATA_W];
            wr_ok[j] = wr_en[j] && is_writable(32'(wa[j]), NREGS);
        end
    end

    // Next array contents; port 1 is applied last so it wins a clash.
    always_comb begin
        mem_d = mem_q;
        for (int unsigned i = 0; i < NREGS; i++) begin
            for (int j = 0; j < 2; j++) begin
                if (wr_ok[j] && (32'(wa[j]) == i)) begin
                    mem_d[i] = wd[j];
                end
            end
        end
    end

    // Array storage; reset overrides any simultaneous write.
    always_ff @(posedge clk) begin
        if (rst) begin
            mem_q <= '{default: '0};
        end else begin
            mem_q <= mem_d;
        end
    end

    // Combinational reads with hardwired r0/r1, range check and forwarding.
    always_comb begin
        rd_data = '0;
        rd_busy = '0;
        for (int k = 0; k < NRD; k++) begin
            ra[k] = rd_addr[k*AW +: AW];
            if (32'(ra[k]) == R0) begin
                rd_data[k*DATA_W +: DATA_W] = '0;
            end else if (32'(ra[k]) == R1) begin
                rd_data[k*DATA_W +: DATA_W] = DATA_W'(1);
            end else if (32'(ra[k]) < NREGS) begin
                rd_data[k*DATA_W +: DATA_W] = mem_q[ra[k]];
                rd_busy[k]                  = busy[ra[k]];
                if (BYPASS != 0) begin
                    // A write landing this cycle also resolves the pending state.
                    if (wr_ok[1] && (wa[1] == ra[k])) begin
                        rd_data[k*DATA_W +: DATA_W] = wd[1];
                        rd_busy[k]                  = 1'b0;
                    end else if (wr_ok[0] && (wa[0] == ra[k])) begin
                        rd_data[k*DATA_W +: DATA_W] = wd[0];
                        rd_busy[k]                  = 1'b0;
                    end
                end
            end
        end
    end

    regfile_scoreboard #(
        .NREGS (NREGS)
    ) u_scoreboard (
        .clk          (clk),
        .rst          (rst),
        .set_en_i     (sb_set_en),
        .set_addr_i   (sb_set_addr),
        .clr_en_i     (wr_en),
        .clr_addr_i   (wr_addr),
        .busy_o       (busy),
        .busy_count_o (busy_count)
    );

endmodule

// File: tb/tb_regfile_sb.sv
// Directed bench: a default instance (16 regs, forwarding on) and a
// 12-register instance with forwarding off.
module tb_regfile_sb;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Instance A: DATA_W=16, NREGS=16, NRD=2, BYPASS=1 (AW=4, CW=5)
    logic        a_rst;
    logic [7:0]  a_rd_addr;
    logic [31:0] a_rd_data;
    logic [1:0]  a_rd_busy;
    logic [1:0]  a_wr_en;
    logic [7:0]  a_wr_addr;
    logic [31:0] a_wr_data;
    logic        a_sb_set_en;
    logic [3:0]  a_sb_set_addr;
    logic [4:0]  a_busy_count;

    // Instance B: NREGS=12, BYPASS=0 (AW=4, CW=4)
    logic        b_rst;
    logic [7:0]  b_rd_addr;
    logic [31:0] b_rd_data;
    logic [1:0]  b_rd_busy;
    logic [1:0]  b_wr_en;
    logic [7:0]  b_wr_addr;
    logic [31:0] b_wr_data;
    logic        b_sb_set_en;
    logic [3:0]  b_sb_set_addr;
    logic [3:0]  b_busy_count;

    regfile_sb u_dut_a (
        .clk         (clk),
        .rst         (a_rst),
        .rd_addr     (a_rd_addr),
        .rd_data     (a_rd_data),
        .rd_busy     (a_rd_busy),
        .wr_en       (a_wr_en),
        .wr_addr     (a_wr_addr),
        .wr_data     (a_wr_data),
        .sb_set_en   (a_sb_set_en),
        .sb_set_addr (a_sb_set_addr),
        .busy_count  (a_busy_count)
    );

    regfile_sb #(
        .NREGS  (12),
        .BYPASS (0)
    ) u_dut_b (
        .clk         (clk),
        .rst         (b_rst),
        .rd_addr     (b_rd_addr),
        .rd_data     (b_rd_data),
        .rd_busy     (b_rd_busy),
        .wr_en       (b_wr_en),
        .wr_addr     (b_wr_addr),
        .wr_data     (b_wr_data),
        .sb_set_en   (b_sb_set_en),
        .sb_set_addr (b_sb_set_addr),
        .busy_count  (b_busy_count)
    );

    int n_total = 0;
    int n_bad   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        a_wr_en     = '0;
        a_sb_set_en = 1'b0;
        b_wr_en     = '0;
        b_sb_set_en = 1'b0;
    endtask

    task automatic a_wr(input int p, input logic [3:0] addr, input logic [15:0] data);
        a_wr_en[p]            = 1'b1;
        a_wr_addr[p*4 +: 4]   = addr;
        a_wr_data[p*16 +: 16] = data;
    endtask

    task automatic a_rd(input int p, input logic [3:0] addr);
        a_rd_addr[p*4 +: 4] = addr;
    endtask

    task automatic a_set(input logic [3:0] addr);
        a_sb_set_en   = 1'b1;
        a_sb_set_addr = addr;
    endtask

    task automatic b_wr(input int p, input logic [3:0] addr, input logic [15:0] data);
        b_wr_en[p]            = 1'b1;
        b_wr_addr[p*4 +: 4]   = addr;
        b_wr_data[p*16 +: 16] = data;
    endtask

    task automatic b_rd(input int p, input logic [3:0] addr);
        b_rd_addr[p*4 +: 4] = addr;
    endtask

    initial begin
        a_rst = 1'b1; b_rst = 1'b1;
        a_rd_addr = '0; a_wr_addr = '0; a_wr_data = '0; a_sb_set_addr = '0;
        b_rd_addr = '0; b_wr_addr = '0; b_wr_data = '0; b_sb_set_addr = '0;
        idle();
        a_rd(0, 4'd0); a_rd(1, 4'd1);
        tick();
        #1;
        check("rst_rd_r0", 32'(a_rd_data[15:0]), 32'h0000);
        check("rst_rd_r1", 32'(a_rd_data[31:16]), 32'h0001);
        tick();
        a_rst = 1'b0; b_rst = 1'b0;
        a_rd(0, 4'd5);
        #1;
        check("rst_cnt", 32'(a_busy_count), 32'd0);
        check("rst_r5", 32'(a_rd_data[15:0]), 32'h0000);

        // Basic write and hardwired reads
        a_wr(0, 4'd5, 16'hBEEF);
        tick(); idle();
        a_rd(0, 4'd5); a_rd(1, 4'd0);
        #1;
        check("wr_r5", 32'(a_rd_data[15:0]), 32'hBEEF);
        check("rd_r0", 32'(a_rd_data[31:16]), 32'h0000);
        a_rd(1, 4'd1);
        #1;
        check("rd_r1", 32'(a_rd_data[31:16]), 32'h0001);

        // Writes and set aimed at hardwired registers are ignored
        a_wr(0, 4'd0, 16'hFFFF); a_wr(1, 4'd1, 16'h1234); a_set(4'd1);
        a_rd(0, 4'd0); a_rd(1, 4'd1);
        #1;
        check("hw_byp_r0", 32'(a_rd_data[15:0]), 32'h0000);
        check("hw_byp_r1", 32'(a_rd_data[31:16]), 32'h0001);
        tick(); idle();
        #1;
        check("hw_r0", 32'(a_rd_data[15:0]), 32'h0000);
        check("hw_r1", 32'(a_rd_data[31:16]), 32'h0001);
        check("hw_cnt", 32'(a_busy_count), 32'd0);

        // Write clash on r7 with pending bit; port 1 wins, bypass clears busy
        a_set(4'd7);
        tick(); idle();
        a_rd(0, 4'd7); a_rd(1, 4'd5);
        #1;
        check("r7_busy", 32'(a_rd_busy[0]), 32'd1);
        check("r7_cnt", 32'(a_busy_count), 32'd1);
        a_wr(0, 4'd7, 16'h1111); a_wr(1, 4'd7, 16'h2222);
        #1;
        check("clash_byp", 32'(a_rd_data[15:0]), 32'h2222);
        check("clash_byp_busy", 32'(a_rd_busy[0]), 32'd0);
        check("nobyp_r5", 32'(a_rd_data[31:16]), 32'hBEEF);
        tick(); idle();
        #1;
        check("clash_store", 32'(a_rd_data[15:0]), 32'h2222);
        check("clash_busy", 32'(a_rd_busy[0]), 32'd0);
        check("clash_cnt", 32'(a_busy_count), 32'd0);

        // Port-0-only forwarding
        a_wr(0, 4'd11, 16'h0B0B); a_rd(1, 4'd11);
        #1;
        check("byp_p0", 32'(a_rd_data[31:16]), 32'h0B0B);
        tick(); idle();

        // Set beats a same-cycle write; a plain write then clears
        a_set(4'd9);
        tick(); idle();
        a_rd(0, 4'd9);
        #1;
        check("r9_busy", 32'(a_rd_busy[0]), 32'd1);
        check("r9_cnt", 32'(a_busy_count), 32'd1);
        a_wr(0, 4'd9, 16'h0909); a_set(4'd9);
        tick(); idle();
        #1;
        check("r9_set_win", 32'(a_rd_busy[0]), 32'd1);
        check("r9_set_cnt", 32'(a_busy_count), 32'd1);
        check("r9_data", 32'(a_rd_data[15:0]), 32'h0909);
        a_wr(1, 4'd9, 16'h9999);
        tick(); idle();
        #1;
        check("r9_clr", 32'(a_rd_busy[0]), 32'd0);
        check("r9_clr_cnt", 32'(a_busy_count), 32'd0);
        check("r9_data2", 32'(a_rd_data[15:0]), 32'h9999);

        // Reset mid-operation
        a_wr(0, 4'd10, 16'hAAAA);
        tick(); idle();
        a_set(4'd2); tick();
        a_set(4'd3); tick();
        a_set(4'd4); tick(); idle();
        #1;
        check("pre_rst_cnt", 32'(a_busy_count), 32'd3);
        a_rst = 1'b1;
        a_wr(0, 4'd10, 16'h5555); a_set(4'd6);
        a_rd(0, 4'd0); a_rd(1, 4'd1);
        #1;
        check("mid_rst_r0", 32'(a_rd_data[15:0]), 32'h0000);
        check("mid_rst_r1", 32'(a_rd_data[31:16]), 32'h0001);
        tick();
        a_rst = 1'b0; idle();
        a_rd(0, 4'd10); a_rd(1, 4'd5);
        #1;
        check("post_rst_r10", 32'(a_rd_data[15:0]), 32'h0000);
        check("post_rst_r5", 32'(a_rd_data[31:16]), 32'h0000);
        check("post_rst_cnt", 32'(a_busy_count), 32'd0);
        a_rd(0, 4'd2);
        #1;
        check("post_rst_busy", 32'(a_rd_busy[0]), 32'd0);
        a_wr(0, 4'd10, 16'h4242);
        tick(); idle();
        a_rd(0, 4'd10);
        #1;
        check("post_rst_wr", 32'(a_rd_data[15:0]), 32'h4242);

        // Instance B: no forwarding, out-of-range addresses
        b_wr(0, 4'd3, 16'h1234);
        tick(); idle();
        b_wr(0, 4'd3, 16'hA5A5); b_rd(0, 4'd3);
        #1;
        check("b_old_val", 32'(b_rd_data[15:0]), 32'h1234);
        tick(); idle();
        #1;
        check("b_new_val", 32'(b_rd_data[15:0]), 32'hA5A5);
        b_wr(0, 4'd14, 16'hFFFF); b_sb_set_en = 1'b1; b_sb_set_addr = 4'd14;
        b_rd(1, 4'd14);
        #1;
        check("b_oor_byp", 32'(b_rd_data[31:16]), 32'h0000);
        check("b_oor_byp_busy", 32'(b_rd_busy[1]), 32'd0);
        tick(); idle();
        #1;
        check("b_oor_rd", 32'(b_rd_data[31:16]), 32'h0000);
        check("b_oor_cnt", 32'(b_busy_count), 32'd0);
        check("b_r3_kept", 32'(b_rd_data[15:0]), 32'hA5A5);
        b_rd(1, 4'd11);
        #1;
        check("b_r11", 32'(b_rd_data[31:16]), 32'h0000);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
